// File: rtl/mux_n_pkg.sv
// rtl/mux_n_pkg.sv - shared mode encodings and default sizes for the registered channel selector
package mux_n_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  localparam int DEF_N = 4;
  localparam int DEF_W = 4;

endpackage

// File: rtl/rr_next_idx.sv
// rtl/rr_next_idx.sv - finds the next enabled channel strictly after ptr, wrapping N-1 -> 0
module rr_next_idx #(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [SW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [SW-1:0] nxt,
  output logic          found
);

  logic [N-1:0] rot;
  int           off;

  // rot[i] is the mask bit of channel ptr+1+i, so ptr itself is tried last
  always_comb begin
    rot = '0;
    off = 0;
    for (int i = 0; i < N; i++) begin
      rot[i] = mask[(int'(ptr) + 1 + i) % N];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    nxt   = SW'((int'(ptr) + 1 + off) % N);
    found = |mask;
  end

endmodule

// File: rtl/mux_n_reg.sv
// rtl/mux_n_reg.sv - registered N-channel selector with direct, round-robin scan and hold modes
module mux_n_reg
  import mux_n_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N*W-1:0] in_bus,
  input  logic [SW-1:0] sel,
  input  logic [1:0]    mode,
  input  logic          en,
  input  logic [N-1:0]  mask,
  output logic [W-1:0]  out,
  output logic          out_valid,
  output logic [SW-1:0] cur_sel,
  output logic          sel_err
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] nxt_idx;
  logic          nxt_found;
  logic          sel_ok;
  logic [W-1:0]  sel_data;
  logic [W-1:0]  scan_data;

  rr_next_idx #(.N(N)) u_next (
    .ptr   (ptr),
    .mask  (mask),
    .nxt   (nxt_idx),
    .found (nxt_found)
  );

  // sel can only exceed N-1 when N is not a power of two
  always_comb begin
    sel_ok    = int'(sel) < N;
    sel_data  = '0;
    scan_data = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(sel) == k)     sel_data  = in_bus[k*W +: W];
      if (int'(nxt_idx) == k) scan_data = in_bus[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      cur_sel   <= '0;
      sel_err   <= 1'b0;
      ptr       <= '0;
    end else if (en) begin
      case (mode)
        MODE_DIRECT: begin
          if (sel_ok) begin
            out       <= sel_data;
            out_valid <= 1'b1;
            cur_sel   <= sel;
            sel_err   <= 1'b0;
            ptr       <= sel;
          end else begin
            out       <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b1;
            ptr       <= cur_sel;
          end
        end
        MODE_SCAN: begin
          sel_err <= 1'b0;
          if (nxt_found) begin
            out       <= scan_data;
            out_valid <= 1'b1;
            cur_sel   <= nxt_idx;
            ptr       <= nxt_idx;
          end else begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          sel_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// tb/tb_mux_n_reg.sv - randomized and directed checks of mux_n_reg (N=4 and N=3) against a channel-level model
module tb_mux_n_reg;
  import mux_n_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        en;
  logic [15:0] bus_a;
  logic [1:0]  sel_a;
  logic [3:0]  mask_a;
  logic [3:0]  out_a;
  logic        valid_a;
  logic [1:0]  cur_a;
  logic        err_a;
  logic [11:0] bus_b;
  logic [1:0]  sel_b;
  logic [2:0]  mask_b;
  logic [3:0]  out_b;
  logic        valid_b;
  logic [1:0]  cur_b;
  logic        err_b;

  always #5 clk = ~clk;

  mux_n_reg #(.N(4), .W(4)) dut_a (
    .clk(clk), .reset(reset), .in_bus(bus_a), .sel(sel_a), .mode(mode), .en(en),
    .mask(mask_a), .out(out_a), .out_valid(valid_a), .cur_sel(cur_a), .sel_err(err_a)
  );

  mux_n_reg #(.N(3), .W(4)) dut_b (
    .clk(clk), .reset(reset), .in_bus(bus_b), .sel(sel_b), .mode(mode), .en(en),
    .mask(mask_b), .out(out_b), .out_valid(valid_b), .cur_sel(cur_b), .sel_err(err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] ch [2][4];
  int m_ptr [2];
  int m_cur [2];
  int m_out [2];
  int m_val [2];
  int m_err [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) bus_a[k*4 +: 4] = ch[0][k];
    for (int k = 0; k < 3; k++) bus_b[k*4 +: 4] = ch[1][k];
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int n, s, mk;
      bit hit;
      n  = (i == 0) ? 4 : 3;
      s  = (i == 0) ? int'(sel_a) : int'(sel_b);
      mk = (i == 0) ? int'(mask_a) : int'(mask_b);
      if (reset) begin
        m_ptr[i] = 0; m_cur[i] = 0; m_out[i] = 0; m_val[i] = 0; m_err[i] = 0;
      end else if (en) begin
        if (mode == MODE_DIRECT) begin
          if (s < n) begin
            m_out[i] = ch[i][s]; m_cur[i] = s; m_ptr[i] = s; m_val[i] = 1; m_err[i] = 0;
          end else begin
            m_out[i] = 0; m_val[i] = 0; m_err[i] = 1; m_ptr[i] = m_cur[i];
          end
        end else if (mode == MODE_SCAN) begin
          m_err[i] = 0;
          hit = 0;
          for (int step = 1; step <= n; step++) begin
            int c;
            c = (m_ptr[i] + step) % n;
            if (!hit && mk[c]) begin
              hit = 1; m_ptr[i] = c; m_cur[i] = c; m_out[i] = ch[i][c];
            end
          end
          m_val[i] = hit ? 1 : 0;
        end else begin
          m_err[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    model_edge();
    #1;
    check("a.out",   32'(out_a),   32'(m_out[0]));
    check("a.valid", 32'(valid_a), 32'(m_val[0]));
    check("a.cur",   32'(cur_a),   32'(m_cur[0]));
    check("a.err",   32'(err_a),   32'(m_err[0]));
    check("b.out",   32'(out_b),   32'(m_out[1]));
    check("b.valid", 32'(valid_b), 32'(m_val[1]));
    check("b.cur",   32'(cur_b),   32'(m_cur[1]));
    check("b.err",   32'(err_b),   32'(m_err[1]));
  endtask

  initial begin
    int seq4 [5];
    int seq2 [4];
    int frozen;
    seq4 = '{1, 2, 3, 0, 1};
    seq2 = '{1, 3, 1, 3};
    ch[0][0] = 4'hA; ch[0][1] = 4'hB; ch[0][2] = 4'hC; ch[0][3] = 4'hD;
    ch[1][0] = 4'h1; ch[1][1] = 4'h2; ch[1][2] = 4'h3; ch[1][3] = 4'h0;
    reset = 1'b1; en = 1'b0; mode = MODE_DIRECT;
    sel_a = 2'd0; sel_b = 2'd0; mask_a = 4'b1111; mask_b = 3'b111;
    drive();

    tick(); tick();
    check("rst.out", 32'(out_a), 32'h0);
    check("rst.valid", 32'(valid_a), 32'h0);
    reset = 1'b0; en = 1'b1;

    sel_a = 2'd2; tick();
    check("dir.out", 32'(out_a), 32'hC);
    check("dir.cur", 32'(cur_a), 32'd2);
    check("dir.valid", 32'(valid_a), 32'd1);
    reset = 1'b1; tick();
    check("midrst.out", 32'(out_a), 32'h0);
    check("midrst.cur", 32'(cur_a), 32'd0);
    reset = 1'b0;

    mode = MODE_SCAN; mask_a = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("scan4.cur", 32'(cur_a), 32'(seq4[j]));
      check("scan4.out", 32'(out_a), 32'(ch[0][seq4[j]]));
    end

    reset = 1'b1; tick(); reset = 1'b0;
    mask_a = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("scan2.cur", 32'(cur_a), 32'(seq2[j]));
    end
    mask_a = 4'b0000;
    tick(); tick();
    check("mask0.cur", 32'(cur_a), 32'd3);
    check("mask0.out", 32'(out_a), 32'hD);
    check("mask0.valid", 32'(valid_a), 32'd0);

    mode = MODE_DIRECT; sel_a = 2'd3; tick();
    mode = MODE_HOLD;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 4; k++) ch[0][k] = 4'($urandom);
      tick();
      check("hold.out", 32'(out_a), 32'hD);
    end
    mode = MODE_SCAN; mask_a = 4'b1111; tick();
    check("hold2scan.cur", 32'(cur_a), 32'd0);

    mode = MODE_DIRECT; sel_b = 2'd3; tick();
    check("n3.err", 32'(err_b), 32'd1);
    check("n3.valid", 32'(valid_b), 32'd0);
    sel_b = 2'd1; tick();
    check("n3.err_clr", 32'(err_b), 32'd0);
    check("n3.out", 32'(out_b), 32'(ch[1][1]));

    mode = MODE_SCAN; tick();
    frozen = int'(cur_a);
    en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      ch[0][j] = 4'($urandom);
      tick();
      check("en0.cur", 32'(cur_a), 32'(frozen));
    end
    en = 1'b1; tick();
    check("en1.cur", 32'(cur_a), 32'((frozen + 1) % 4));

    for (int j = 0; j < 400; j++) begin
      reset  = ($urandom_range(0, 31) == 0);
      en     = ($urandom_range(0, 7) != 0);
      mode   = 2'($urandom);
      sel_a  = 2'($urandom);
      sel_b  = 2'($urandom);
      mask_a = 4'($urandom);
      mask_b = 3'($urandom);
      for (int k = 0; k < 4; k++) begin
        ch[0][k] = 4'($urandom);
        ch[1][k] = 4'($urandom);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised, registered N-channel, W-bit-wide selector. Successor to the 1-bit combinational 4:1 multiplexer.
- Adds two selection modes: direct (external select) and auto-scan (internal round-robin pointer that skips masked channels).
- Adds hold mode, output valid flag and out-of-range select detection.
- Sits between the ALU operand/result sources and the display/result registers.

Parameters:
- N, 4, number of input channels (2..16).
- W, 4, width of each channel in bits (1..32).
- SW, $clog2(N), select/pointer width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_bus  in  N*W  packed channels; channel k occupies in_bus[k*W +: W].
- sel  in  SW  channel select used in direct mode.
- mode  in  2  00 direct, 01 scan, 10 hold, 11 reserved (treated as hold).
- en  in  1  advance/update enable; when low, all registers keep their value.
- mask  in  N  scan enable per channel; bit k=1 means channel k takes part in scan.
- out  out  W  registered selected data.
- out_valid  out  1  out holds a legitimately selected channel.
- cur_sel  out  SW  channel index currently presented on out.
- sel_err  out  1  sel >= N was seen in direct mode (registered, one cycle per occurrence).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All state updates occur only on the rising edge of clk.
- Reset values: out=0, out_valid=0, cur_sel=0, sel_err=0, scan pointer=0.
- Reset has priority over en and mode. Reset in mid-scan returns the pointer to 0. The next scan step after reset is released starts the search from channel 1.
- Latency is 1 cycle from input/select change (with en=1) to out.
- Direct mode (00), en=1:
  - sel<N: out<=channel[sel], cur_sel<=sel, out_valid<=1, sel_err<=0.
  - sel>=N (only possible when N is not a power of 2): out<=0, out_valid<=0, sel_err<=1, cur_sel unchanged.
  - The scan pointer is loaded with cur_sel's new value, so a later switch to scan mode resumes from that channel.
- Scan mode (01), en=1:
  - Pointer moves to the next channel after the current pointer, in ascending order with wrap N-1 -> 0, whose mask bit is 1.
  - out<=that channel's data, cur_sel<=pointer, out_valid<=1, sel_err<=0.
  - Exactly one mask bit set, and it is the current channel: the pointer stays on that channel and out is refreshed each cycle.
  - mask=0: pointer, cur_sel and out hold; out_valid<=0.
  - Masked channels are never presented.
  - A mask change takes effect on the next step.
- Hold mode (10/11): out, cur_sel and pointer hold. out_valid holds. sel_err<=0.
- en=0 in any mode: every register holds, including sel_err.
- A mode change takes effect on the same edge as the new mode is sampled. There is no idle cycle between modes.
- Data is not re-sampled in hold mode. In scan mode, out reflects input data at the sampling edge, not the current input.

Decomposition:
- Package mux_n_pkg holds the mode constants MODE_DIRECT=2'b00, MODE_SCAN=2'b01, MODE_HOLD=2'b10, and the default N/W values.
- One sub-module, rr_next_idx (combinational, parametrised by N). Inputs: current pointer and mask. Outputs: next index and a found flag. It uses a rotate-and-priority-encode search.
- Top level holds the output register, pointer register and mode case.

Test Plan:
- Reset, then direct mode with N=4, W=4, in_bus={4'hD,4'hC,4'hB,4'hA}, sel=2, en=1 -> after 1 edge out=4'hC, cur_sel=2, out_valid=1. Assert reset mid-stream -> next edge out=0, out_valid=0, cur_sel=0.
- Scan mode, mask=4'b1111, pointer 0, 5 edges -> cur_sel sequence 1,2,3,0,1 with matching data A..D, out_valid=1 throughout.
- Scan mode, mask=4'b1010, pointer 0 -> cur_sel 1,3,1,3; channels 0 and 2 never appear. Then mask=0 -> out and cur_sel frozen, out_valid=0.
- Direct sel=3, then switch to hold for 3 edges while changing in_bus -> out stays 4'hD. Then switch to scan with mask=4'b1111 -> cur_sel 0 next.
- With N=3, direct sel=3 -> out=0, out_valid=0, sel_err=1 for one cycle. Then sel=1 -> sel_err=0 and out=channel 1.
- en=0 in scan mode for 4 edges -> no pointer movement. Re-assert en -> the sequence continues from the frozen channel.
